// File: rtl/booth_mult_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : booth_mult_arbiter
// Brief    : Round-robin sequencer sharing one free-running booth_mult among
//            NREQ requesters; optional wait-phase timeout (BOOTH_ARB_TIMEOUT_EN).
// Revision : 1.0
// ============================================================================
module booth_mult_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]      rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [WIDTH-1:0]        mult_a,
    output logic [WIDTH-1:0]        mult_b,
    input  logic                    mult_done,
    input  logic [2*WIDTH-1:0]      mult_m
);

    localparam int c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("booth_mult_arbiter: unsupported NREQ/TIMEOUT");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [c_ptr_w-1:0]   r_ptr;
    logic [c_ptr_w-1:0]   w_cand;
    logic [c_ptr_w-1:0]   w_win_idx;
    logic                 w_win_found;
    logic                 w_grant;
    logic                 w_capture;
    logic                 w_timeout;
    logic                 w_tmo_hit;

    // Round-robin search starting one past the last served requester.
    always_comb begin
        w_cand      = '0;
        w_win_idx   = '0;
        w_win_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = c_ptr_w'((32'(r_ptr) + k) % NREQ);
            if (!w_win_found && req[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(TIMEOUT + 1);
    logic [c_tmo_w-1:0] r_tmo_cnt;

    assign w_tmo_hit = (r_tmo_cnt == c_tmo_w'(TIMEOUT));

    // Restarts on entry to each wait phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (w_grant || (r_state == WAIT1 && mult_done)) begin
            r_tmo_cnt <= '0;
        end else if (r_state == WAIT1 || r_state == WAIT2) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (w_timeout) begin
            rsp_err <= 1'b1;
        end else if (w_capture || r_state == RESP) begin
            rsp_err <= 1'b0;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // The first done after grant may reflect operands sampled before the
    // grant edge, so WAIT1 discards it and WAIT2 takes the next one.
    always_comb begin
        w_state_nx = r_state;
        w_grant    = 1'b0;
        w_capture  = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_found) begin
                    w_grant    = 1'b1;
                    w_state_nx = WAIT1;
                end
            end
            WAIT1: begin
                if (mult_done) begin
                    w_state_nx = WAIT2;
                end else if (w_tmo_hit) begin
                    w_timeout  = 1'b1;
                    w_state_nx = RESP;
                end
            end
            WAIT2: begin
                if (mult_done) begin
                    w_capture  = 1'b1;
                    w_state_nx = RESP;
                end else if (w_tmo_hit) begin
                    w_timeout  = 1'b1;
                    w_state_nx = RESP;
                end
            end
            RESP: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            mult_a    <= '0;
            mult_b    <= '0;
            r_ptr     <= c_ptr_w'(NREQ - 1);
        end else begin
            if (w_grant) begin
                gnt    <= NREQ'(1) << w_win_idx;
                mult_a <= req_a[int'(w_win_idx)*WIDTH +: WIDTH];
                mult_b <= req_b[int'(w_win_idx)*WIDTH +: WIDTH];
                r_ptr  <= w_win_idx;
            end
            if (w_capture) begin
                rsp_data  <= mult_m;
                rsp_valid <= gnt;
            end
            if (w_timeout) begin
                rsp_data  <= '0;
                rsp_valid <= gnt;
            end
            if (r_state == RESP) begin
                rsp_valid <= '0;
                gnt       <= '0;
            end
        end
    end

    assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_booth_mult_arbiter
// Brief    : Scoreboard bench with a free-running behavioural multiplier model.
// Revision : 1.0
// ============================================================================
module tb_booth_mult_arbiter;

    localparam int WIDTH   = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int MPER    = 10;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rsp_valid;
    logic [2*WIDTH-1:0]    rsp_data;
    logic                  rsp_err;
    logic                  busy;
    logic [WIDTH-1:0]      mult_a;
    logic [WIDTH-1:0]      mult_b;
    logic                  mult_done;
    logic [2*WIDTH-1:0]    mult_m;

    booth_mult_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .mult_a(mult_a), .mult_b(mult_b),
        .mult_done(mult_done), .mult_m(mult_m)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sprod(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] p;
        p = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
        return p;
    endfunction

    // Free-running multiplier model: samples operands at each period start.
    logic [3:0] r_mcnt;
    logic [7:0] r_op_a, r_op_b;
    logic       freeze;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcnt <= '0;
            r_op_a <= '0;
            r_op_b <= '0;
        end else if (r_mcnt == 4'(MPER - 1)) begin
            r_mcnt <= '0;
            r_op_a <= mult_a;
            r_op_b <= mult_b;
        end else begin
            r_mcnt <= r_mcnt + 4'd1;
        end
    end

    assign mult_done = (r_mcnt == 4'(MPER - 1)) && !freeze;
    assign mult_m    = sprod(r_op_a, r_op_b);

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [NREQ-1:0] rearm;
    logic [7:0]  rearm_a[NREQ];
    logic [7:0]  rearm_b[NREQ];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // mode 0: normal job, 1: no response expected, 2: timeout response expected
    task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b, input int mode);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req[i] = 1'b1;
        if (mode == 0) sb.push_back('{i, sprod(a, b), 1'b0});
        else if (mode == 2) sb.push_back('{i, 16'h0000, 1'b1});
    endtask

    task automatic serve(input int n);
        int got;
        got = 0;
        for (int cyc = 0; cyc < 3000 && got < n; cyc++) begin
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("extra_rsp", 32'(rsp_valid), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_idx",  32'(rsp_valid), 32'(4'b0001 << e.idx));
                    chk("rsp_gnt",  32'(gnt),       32'(4'b0001 << e.idx));
                    chk("rsp_data", 32'(rsp_data),  32'(e.data));
                    chk("rsp_err",  32'(rsp_err),   32'(e.err));
                end
                got++;
                for (int i = 0; i < NREQ; i++) begin
                    if (rsp_valid[i]) begin
                        if (rearm[i]) begin
                            rearm[i] = 1'b0;
                            issue(i, rearm_a[i], rearm_b[i], 0);
                        end else begin
                            req[i] = 1'b0;
                        end
                    end
                end
            end
            @(negedge clk);
        end
        if (got < n) chk("rsp_missing", 32'(got), 32'(n));
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        req_a  = '0;
        req_b  = '0;
        freeze = 1'b0;
        rearm  = '0;
        for (int i = 0; i < NREQ; i++) begin
            rearm_a[i] = '0;
            rearm_b[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_gnt",   32'(gnt),       32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_data",  32'(rsp_data),  32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_mult",  32'({mult_a, mult_b}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requests, unsigned and signed operands
        issue(0, 8'd7, 8'd6, 0);
        serve(1);
        issue(1, 8'hF9, 8'd5, 0);
        serve(1);
        issue(3, 8'h80, 8'h80, 0);
        serve(1);

        // Contention right after reset: 0,1,2,3 then re-armed 2
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rearm[2]   = 1'b1;
        rearm_a[2] = 8'd9;
        rearm_b[2] = 8'hFD;
        issue(0, 8'd2,   8'd3,   0);
        issue(1, 8'hFF,  8'hFF,  0);
        issue(2, 8'd10,  8'd10,  0);
        issue(3, 8'd127, 8'h80,  0);
        serve(5);

        // Multiplier keeps computing 3*3 between jobs; new job must not see 9
        issue(0, 8'd3, 8'd3, 0);
        serve(1);
        issue(0, 8'd5, 8'hFC, 0);
        serve(1);

        // Reset while in WAIT2
        issue(1, 8'd12, 8'd12, 1);
        for (int n = 0; n < 50 && gnt == '0; n++) @(negedge clk);
        chk("mid_gnt", 32'(gnt), 32'h2);
        for (int n = 0; n < 50 && !mult_done; n++) @(negedge clk);
        chk("mid_done1", 32'(mult_done), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_gnt0",   32'(gnt),       32'h0);
        chk("mid_valid0", 32'(rsp_valid), 32'h0);
        chk("mid_data0",  32'(rsp_data),  32'h0);
        chk("mid_err0",   32'(rsp_err),   32'h0);
        chk("mid_busy0",  32'(busy),      32'h0);
        chk("mid_mult0",  32'({mult_a, mult_b}), 32'h0);
        req = '0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_norsp", 32'(rsp_valid), 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        issue(2, 8'd11, 8'd12, 0);
        serve(1);

`ifdef BOOTH_ARB_TIMEOUT_EN
        begin
            int lat;
            freeze = 1'b1;
            issue(0, 8'd4, 8'd4, 2);
            for (int n = 0; n < 50 && gnt == '0; n++) @(negedge clk);
            lat = 0;
            while (rsp_valid == '0 && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            chk("tmo_latency", 32'(lat), 32'd17);
            serve(1);
            freeze = 1'b0;
        end
`endif

        repeat (3) @(negedge clk);
        chk("end_valid", 32'(rsp_valid), 32'h0);
        chk("end_busy",  32'(busy),      32'h0);
        chk("end_sb",    32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
